cic_decim_multi: RTL and testbench

Multi-channel, runtime-configurable CIC decimator. It succeeds the fixed 5-stage, fixed-ratio CIC used in the AM receiver chain.
- Stage count is a parameter.
- Decimation ratio and output gain are run-time inputs.
- Input is qualified by a valid strobe, so the block can sit behind a CIC or mixer that runs slower than the clock.
- The comb section is pipelined and the output is rounded and saturated.
- It sits between the 1-bit/NCO mixer stage and the FIR/demodulator, processing CHANNELS lanes (e.g. I and Q) in lock-step.

---
 rtl/cic_decim_multi.sv | 170 +++++++++++++++++
 tb/tb_cic_decim_multi.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_multi.sv
`default_nettype none
// ============================================================================
// Module      : cic_decim_multi
// Description : Multi-channel CIC decimator with a runtime decimation ratio
//               and output gain. It uses a strobe-qualified registered
//               integrator cascade and a pipelined comb section, followed by
//               a rounded, saturated output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_decim_multi #(
  parameter int STAGES     = 5,
  parameter int WIDTH      = 81,
  parameter int BITS_IN    = 16,
  parameter int BITS_OUT   = 16,
  parameter int CHANNELS   = 2,
  parameter int GAIN_BITS  = 8,
  parameter int COUNT_BITS = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  input  logic [CHANNELS*BITS_IN-1:0]  x_in,
  input  logic [COUNT_BITS-1:0]        decim,
  input  logic [GAIN_BITS-1:0]         gain,
  output logic [CHANNELS*BITS_OUT-1:0] x_out,
  output logic                         out_valid,
  output logic [CHANNELS-1:0]          out_sat
);

  localparam int MAX_SHIFT = WIDTH - BITS_OUT;
  localparam int SH_BITS   = $clog2(MAX_SHIFT + 1);
  localparam int GW        = ((GAIN_BITS > SH_BITS) ? GAIN_BITS : SH_BITS) + 1;
  localparam logic signed [WIDTH:0] SAT_HI =
    {{(WIDTH-BITS_OUT+2){1'b0}}, {(BITS_OUT-1){1'b1}}};
  localparam logic signed [WIDTH:0] SAT_LO =
    {{(WIDTH-BITS_OUT+2){1'b1}}, {(BITS_OUT-1){1'b0}}};
  localparam logic [COUNT_BITS-1:0] R_MIN = COUNT_BITS'(2);
  localparam logic [COUNT_BITS-1:0] ONE   = COUNT_BITS'(1);

  logic [COUNT_BITS-1:0] r_count;
  logic [COUNT_BITS-1:0] r_reff;
  logic [COUNT_BITS-1:0] w_decim_eff;
  logic                  r_cap;
  logic [STAGES:0]       r_vld;
  logic [GAIN_BITS-1:0]  r_gain [STAGES+1];
  logic                  r_out_valid;
  logic [GW-1:0]         w_gain_ext;
  logic [GW-1:0]         w_shift;
  logic signed [WIDTH:0] w_rnd;

  // Ratios below 2 would make the comb degenerate, so they are forced to 2
  assign w_decim_eff = (decim < R_MIN) ? R_MIN : decim;

  // Frame counter: the ratio is re-latched only at frame boundaries
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
      r_reff  <= w_decim_eff;
      r_cap   <= 1'b0;
    end else begin
      r_cap <= 1'b0;
      if (in_valid) begin
        if (r_count == r_reff - ONE) begin
          r_count <= '0;
          r_reff  <= w_decim_eff;
          r_cap   <= 1'b1;
        end else begin
          r_count <= r_count + ONE;
        end
      end
    end
  end

  // Per-stage valids and gain travel with each captured sample through the comb
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k <= STAGES; k++) r_gain[k] <= '0;
    end else begin
      r_vld       <= {r_vld[STAGES-1:0], r_cap};
      r_out_valid <= r_vld[STAGES];
      if (r_cap) r_gain[0] <= gain;
      for (int k = 1; k <= STAGES; k++) begin
        if (r_vld[k-1]) r_gain[k] <= r_gain[k-1];
      end
    end
  end

  assign out_valid = r_out_valid;

  // Runtime shift amount, clamped at zero when the gain exceeds the headroom
  assign w_gain_ext = GW'(r_gain[STAGES]);
  assign w_shift    = (w_gain_ext >= GW'(MAX_SHIFT)) ? '0 : (GW'(MAX_SHIFT) - w_gain_ext);
  assign w_rnd      = (w_shift == '0) ? '0 : ((WIDTH+1)'(1) << (w_shift - GW'(1)));

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [WIDTH-1:0] integ  [STAGES];
      logic signed [WIDTH-1:0] comb_y [STAGES+1];
      logic signed [WIDTH-1:0] comb_d [STAGES];
      logic signed [WIDTH-1:0] w_x_ext;
      logic signed [WIDTH:0]   w_sum;
      logic signed [WIDTH:0]   w_shd;
      logic [BITS_OUT-1:0]     w_xo;
      logic                    w_sat;
      logic [BITS_OUT-1:0]     r_xo;
      logic                    r_sat;

      assign w_x_ext = {{(WIDTH-BITS_IN){x_in[c*BITS_IN+BITS_IN-1]}}, x_in[c*BITS_IN +: BITS_IN]};

      // Registered integrator cascade; each stage adds the previous stage's old value
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int k = 0; k < STAGES; k++) integ[k] <= '0;
        end else if (in_valid) begin
          integ[0] <= integ[0] + w_x_ext;
          for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
        end
      end

      // Capture and comb pipeline; stage k fires one cycle after stage k-1
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int k = 0; k <= STAGES; k++) comb_y[k] <= '0;
          for (int k = 0; k < STAGES; k++)  comb_d[k] <= '0;
        end else begin
          if (r_cap) comb_y[0] <= integ[STAGES-1];
          for (int k = 1; k <= STAGES; k++) begin
            if (r_vld[k-1]) begin
              comb_y[k]   <= comb_y[k-1] - comb_d[k-1];
              comb_d[k-1] <= comb_y[k-1];
            end
          end
        end
      end

      // Round half up, barrel shift, then clip to the output range
      always_comb begin
        w_sum = {comb_y[STAGES][WIDTH-1], comb_y[STAGES]} + w_rnd;
        w_shd = w_sum >>> w_shift;
        w_xo  = w_shd[BITS_OUT-1:0];
        w_sat = 1'b0;
        if (w_shd > SAT_HI) begin
          w_xo  = SAT_HI[BITS_OUT-1:0];
          w_sat = 1'b1;
        end else if (w_shd < SAT_LO) begin
          w_xo  = SAT_LO[BITS_OUT-1:0];
          w_sat = 1'b1;
        end
      end

      // Output register holds its value between output pulses
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_xo  <= '0;
          r_sat <= 1'b0;
        end else if (r_vld[STAGES]) begin
          r_xo  <= w_xo;
          r_sat <= w_sat;
        end
      end

      assign x_out[c*BITS_OUT +: BITS_OUT] = r_xo;
      assign out_sat[c]                    = r_sat;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_decim_multi
// Description : Self-checking bench for cic_decim_multi. The reference model
//               computes each output from closed-form binomial sums over the
//               accepted-sample history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decim_multi;

  localparam int ST = 3;
  localparam int W  = 24;
  localparam int BO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] decim = 16'd4;
  logic [7:0]  gain = 8'd16;
  logic [15:0] x_out;
  logic        out_valid;
  logic [1:0]  out_sat;

  cic_decim_multi #(
    .STAGES(ST), .WIDTH(W), .BITS_IN(8), .BITS_OUT(BO),
    .CHANNELS(2), .GAIN_BITS(8), .COUNT_BITS(16)
  ) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .x_in(x_in),
    .decim(decim), .gain(gain), .x_out(x_out),
    .out_valid(out_valid), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rst_seen = 1'b0;

  // Reference model state
  longint hist [2][4096];
  longint caps [2][1024];
  int     nhist = 0;
  int     ncaps = 0;
  int     m_cnt = 0;
  int     m_reff = 2;

  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [1:0] sat;
    int         due;
  } exp_t;
  exp_t expq[$];
  int   ovq[$];
  int   logq[$];

  function automatic int eff(logic [15:0] d);
    return (d < 16'd2) ? 2 : int'(d);
  endfunction

  function automatic longint binom(int n, int k);
    longint r;
    if (n < k || n < 0) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after t accepted samples; the registered cascade delays it by ST-1 samples
  function automatic longint integ_out(int lane, int t);
    longint s = 0;
    for (int j = 1; j <= t - ST + 1; j++) s += binom(t - j, ST - 1) * hist[lane][j-1];
    return s;
  endfunction

  // ST-th difference of the captured sequence (zero before the first capture)
  function automatic longint comb_out(int lane, int n);
    longint y = 0;
    for (int k = 0; k <= ST; k++) begin
      if (n - k >= 0) begin
        if (k % 2 == 0) y += binom(ST, k) * caps[lane][n-k];
        else            y -= binom(ST, k) * caps[lane][n-k];
      end
    end
    return y;
  endfunction

  function automatic logic [8:0] out_model(longint y_in, int g);
    longint y;
    longint v;
    int s;
    y = y_in & 64'shFFFFFF;
    if (y >= 64'sh800000) y = y - 64'sh1000000;
    s = (W - BO) - g;
    if (s < 0) s = 0;
    v = y;
    if (s > 0) v = (y + (longint'(1) << (s - 1))) >>> s;
    if (v > 127)  return {1'b1, 8'h7F};
    if (v < -128) return {1'b1, 8'h80};
    return {1'b0, v[7:0]};
  endfunction

  function automatic void capture();
    exp_t e;
    logic [8:0] r0;
    logic [8:0] r1;
    for (int l = 0; l < 2; l++) caps[l][ncaps] = integ_out(l, nhist);
    ncaps++;
    r0 = out_model(comb_out(0, ncaps - 1), int'(gain));
    r1 = out_model(comb_out(1, ncaps - 1), int'(gain));
    e.x0  = r0[7:0];
    e.x1  = r1[7:0];
    e.sat = {r1[8], r0[8]};
    e.due = cyc + ST + 2;
    expq.push_back(e);
  endfunction

  // One clock: update the model with the inputs seen at this edge
  task automatic tick();
    @(posedge clk);
    cyc++;
    rst_seen = rst;
    if (rst) begin
      nhist = 0; ncaps = 0; m_cnt = 0; m_reff = eff(decim);
      expq.delete();
    end else if (in_valid) begin
      hist[0][nhist] = longint'($signed(x_in[7:0]));
      hist[1][nhist] = longint'($signed(x_in[15:8]));
      nhist++;
      if (m_cnt == m_reff - 1) begin
        m_cnt = 0;
        m_reff = eff(decim);
        capture();
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic feed(int n, logic [7:0] a, logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      x_in = {b, a}; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Scoreboard: every pulse must match the next model output at the exact cycle
  always @(negedge clk) begin
    if (rst_seen) begin
      vectors++;
      if (out_valid !== 1'b0 || x_out !== 16'h0 || out_sat !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d out_valid=%b x_out=%h out_sat=%b want 0/0000/00",
                 cyc, out_valid, x_out, out_sat);
      end
    end else if (out_valid === 1'b1) begin
      ovq.push_back(cyc);
      logq.push_back(int'($signed(x_out[7:0])));
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out cyc=%0d x_out=%h out_sat=%b want no pulse", cyc, x_out, out_sat);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (x_out !== {e.x1, e.x0} || out_sat !== e.sat || cyc != e.due) begin
          miscompares++;
          $display("FAIL out_sample cyc=%0d x_out=%h sat=%b want x_out=%h sat=%b at cyc=%0d",
                   cyc, x_out, out_sat, {e.x1, e.x0}, e.sat, e.due);
        end
      end
    end else if (expq.size() > 0 && expq[0].due <= cyc) begin
      exp_t e;
      e = expq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_out cyc=%0d out_valid=0 want pulse x_out=%h due=%0d",
               cyc, {e.x1, e.x0}, e.due);
    end
  end

  typedef struct {
    logic [7:0] g;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] esat;
  } vec_t;
  vec_t tbl[7];

  initial begin
    // Steady-state values for constant input, R=4, 3 stages (R^3 = 64)
    tbl[0] = '{8'd16, 8'd1,   8'd1,   8'd64,  8'd64,  2'b00};
    tbl[1] = '{8'd15, 8'd1,   8'd1,   8'd32,  8'd32,  2'b00};
    tbl[2] = '{8'd9,  8'd1,   8'd1,   8'd1,   8'd1,   2'b00};
    tbl[3] = '{8'd8,  8'd1,   8'd1,   8'd0,   8'd0,   2'b00};
    tbl[4] = '{8'd16, 8'd127, 8'h80,  8'd127, 8'h80,  2'b11};
    tbl[5] = '{8'd20, 8'd1,   8'd1,   8'd64,  8'd64,  2'b00};
    tbl[6] = '{8'd16, 8'hFF,  8'd2,   8'hC0,  8'h7F,  2'b10};

    decim = 16'd4;
    gain  = 8'd16;
    do_reset(3);
    check("reset_x_out", int'(x_out), 0);

    for (int i = 0; i < 7; i++) begin
      gain = tbl[i].g;
      decim = 16'd4;
      do_reset(2);
      logq.delete();
      feed(24, tbl[i].a, tbl[i].b);
      drain(8);
      check($sformatf("steady%0d_lane0", i), int'(x_out[7:0]), int'(tbl[i].e0));
      check($sformatf("steady%0d_lane1", i), int'(x_out[15:8]), int'(tbl[i].e1));
      check($sformatf("steady%0d_sat", i), int'(out_sat), int'(tbl[i].esat));
      if (i == 0) begin
        check("first_out0", logq.size() > 0 ? logq[0] : -999, 4);
        check("first_out1", logq.size() > 1 ? logq[1] : -999, 44);
        check("first_out2", logq.size() > 2 ? logq[2] : -999, 64);
      end
    end

    // in_valid 1-of-3: same samples, outputs every 12 cycles
    gain = 8'd16; decim = 16'd4;
    do_reset(2);
    ovq.delete(); logq.delete();
    for (int i = 0; i < 48; i++) begin
      x_in = 16'h0101; in_valid = (i % 3 == 0);
      tick();
    end
    drain(8);
    check("gap_count", ovq.size(), 4);
    for (int i = 1; i < ovq.size(); i++) check("gap_spacing", ovq[i] - ovq[i-1], 12);
    check("gap_seq3", logq.size() > 3 ? logq[3] : -999, 64);

    // decim 4 -> 8 mid-frame: current frame still closes after 4 samples
    gain = 8'd16; decim = 16'd4;
    do_reset(2);
    ovq.delete();
    feed(10, 8'd1, 8'd1);
    decim = 16'd8;
    feed(2, 8'd1, 8'd1);
    drain(6);
    check("decim_change_count", ovq.size(), 3);
    feed(32, 8'd1, 8'd1);
    drain(8);
    check("decim_r8_count", ovq.size(), 7);
    // 8^3 = 512 exceeds the 8-bit output range, so it clips
    check("decim_r8_lane0", int'($signed(x_out[7:0])), 127);
    check("decim_r8_sat", int'(out_sat), 3);

    // Reset pulse while a sample is in the comb pipeline
    gain = 8'd16; decim = 16'd4;
    do_reset(2);
    ovq.delete();
    feed(4, 8'd1, 8'd1);
    drain(1);
    do_reset(1);
    drain(10);
    check("rst_mid_no_pulse", ovq.size(), 0);
    check("rst_mid_x_out", int'(x_out), 0);
    logq.delete();
    feed(16, 8'd1, 8'd1);
    drain(8);
    check("restart_out0", logq.size() > 0 ? logq[0] : -999, 4);
    check("restart_out1", logq.size() > 1 ? logq[1] : -999, 44);
    check("restart_out3", logq.size() > 3 ? logq[3] : -999, 64);

    // Randomized segments with gaps, decim changes (including 0 and 1) and varied gain
    for (int seg = 0; seg < 6; seg++) begin
      gain  = 8'($urandom_range(6, 20));
      decim = 16'($urandom_range(0, 5));
      do_reset(1);
      for (int i = 0; i < 300; i++) begin
        x_in = 16'($urandom);
        in_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 40) == 0) decim = 16'($urandom_range(0, 5));
        tick();
      end
      drain(10);
    end

    check("pending_outputs", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
